alu_seq: RTL and testbench

- Command sequencer that drives the ALU's operator and A/B buses and consumes its C_bus and Z outputs.
- Executes single ALU ops, plus multi-cycle iterative commands built from ALU primitives: multiply by repeated add, and shift by N.
- Iteration counting uses the ALU's DECA op, and loop exit uses the registered Z flag.
- Sits between the datapath controller and the combinational ALU instance.

---
 rtl/alu_seq_pkg.sv | 37 +++
 rtl/alu_seq_if.sv | 46 ++++
 rtl/alu_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command sequencer: ALU operator codes, command codes and FSM states.
// Optional overflow detection in alu_seq is enabled by defining ALU_SEQ_OVF_EN.
package alu_seq_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_PASS = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_ZER  = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_DECA = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_MUL2 = 3'd5;
  localparam logic [ALU_OP_W-1:0] ALU_DIV2 = 3'd6;

  typedef enum logic [1:0] {
    CMD_SINGLE = 2'd0,
    CMD_MUL    = 2'd1,
    CMD_SHL    = 2'd2,
    CMD_SHR    = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_CLR  = 3'd2,
    S_CHK  = 3'd3,
    S_BODY = 3'd4,
    S_DEC  = 3'd5,
    S_DONE = 3'd6
  } state_e;

  // Code 7 has no ALU meaning, so it is folded onto ZER before it can reach the bus.
  function automatic logic [ALU_OP_W-1:0] remapOp(input logic [ALU_OP_W-1:0] op);
    return (op == 3'd7) ? ALU_ZER : op;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Bundles the controller-facing command/result signals and the ALU-facing buses of alu_seq.
// The ovf signal exists only when ALU_SEQ_OVF_EN is defined.
interface alu_seq_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
);

  logic              start;
  logic [1:0]        cmd;
  logic [OP_W-1:0]   op_in;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              zero;
`ifdef ALU_SEQ_OVF_EN
  logic              ovf;
`endif
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_c;
  logic              alu_z;

`ifdef ALU_SEQ_OVF_EN
  modport master (
    output start, cmd, op_in, opa, opb, alu_c, alu_z,
    input  busy, done, result, zero, ovf, alu_a, alu_b, alu_op
  );
  modport slave (
    input  start, cmd, op_in, opa, opb, alu_c, alu_z,
    output busy, done, result, zero, ovf, alu_a, alu_b, alu_op
  );
`else
  modport master (
    output start, cmd, op_in, opa, opb, alu_c, alu_z,
    input  busy, done, result, zero, alu_a, alu_b, alu_op
  );
  modport slave (
    input  start, cmd, op_in, opa, opb, alu_c, alu_z,
    output busy, done, result, zero, alu_a, alu_b, alu_op
  );
`endif

endinterface

// File: rtl/alu_seq.sv
// Command sequencer driving a combinational ALU: single ops plus iterative MUL/SHL/SHR loops.
// Define ALU_SEQ_OVF_EN to add the sticky ovf output for MUL wrap and SHL bit loss.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  state_e                state_q, state_d;
  cmd_e                  cmd_q, cmd_d;
  logic [ALU_OP_W-1:0]   opIn_q, opIn_d;
  logic [DATA_W-1:0]     ac_q, ac_d;
  logic [DATA_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]     opb_q, opb_d;
  logic                  zf_q, zf_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic                  zero_q, zero_d;
`ifdef ALU_SEQ_OVF_EN
  logic                  ovf_q, ovf_d;
`endif

  logic [ALU_OP_W-1:0]   aluOp;
  logic [DATA_W-1:0]     aluA;
  logic [DATA_W-1:0]     aluB;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cmd_q    <= CMD_SINGLE;
      opIn_q   <= ALU_ZER;
      ac_q     <= '0;
      cnt_q    <= '0;
      opb_q    <= '0;
      zf_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      opIn_q   <= opIn_d;
      ac_q     <= ac_d;
      cnt_q    <= cnt_d;
      opb_q    <= opb_d;
      zf_q     <= zf_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ALU_SEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // ALU drive depends only on registered state, so it never loops back through alu_c.
  always_comb begin
    aluOp = ALU_ZER;
    aluA  = '0;
    aluB  = '0;
    case (state_q)
      S_EXEC: begin
        aluOp = opIn_q;
        aluA  = cnt_q;
        aluB  = opb_q;
      end
      S_CLR: begin
        if (cmd_q != CMD_MUL) begin
          aluOp = ALU_PASS;
          aluB  = opb_q;
        end
      end
      S_CHK: begin
        aluOp = ALU_PASS;
        aluB  = cnt_q;
      end
      S_BODY: begin
        if (!zf_q) begin
          case (cmd_q)
            CMD_MUL: begin
              aluOp = ALU_ADD;
              aluA  = ac_q;
              aluB  = opb_q;
            end
            CMD_SHL: begin
              aluOp = ALU_MUL2;
              aluB  = ac_q;
            end
            default: begin
              aluOp = ALU_DIV2;
              aluB  = ac_q;
            end
          endcase
        end
      end
      S_DEC: begin
        aluOp = ALU_DECA;
        aluA  = cnt_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    opIn_d   = opIn_q;
    ac_d     = ac_q;
    cnt_d    = cnt_q;
    opb_d    = opb_q;
    zf_d     = zf_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cmd_d   = cmd_e'(bus.cmd);
          opIn_d  = remapOp(ALU_OP_W'(bus.op_in));
          opb_d   = bus.opb;
          cnt_d   = bus.opa;
`ifdef ALU_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = (cmd_e'(bus.cmd) == CMD_SINGLE) ? S_EXEC : S_CLR;
        end
      end
      S_EXEC: begin
        result_d = bus.alu_c;
        zero_d   = bus.alu_z;
        state_d  = S_DONE;
      end
      S_CLR: begin
        ac_d    = bus.alu_c;
        state_d = S_CHK;
      end
      S_CHK: begin
        zf_d    = bus.alu_z;
        state_d = S_BODY;
      end
      S_BODY: begin
        if (zf_q) begin
          result_d = ac_q;
          zero_d   = (ac_q == '0);
          state_d  = S_DONE;
        end else begin
`ifdef ALU_SEQ_OVF_EN
          if (cmd_q == CMD_MUL && bus.alu_c < ac_q)
            ovf_d = 1'b1;
          if (cmd_q == CMD_SHL && ac_q[DATA_W-1])
            ovf_d = 1'b1;
`endif
          ac_d    = bus.alu_c;
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        cnt_d   = bus.alu_c;
        zf_d    = bus.alu_z;
        state_d = S_BODY;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.alu_op = OP_W'(aluOp);
  assign bus.alu_a  = aluA;
  assign bus.alu_b  = aluB;
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
`ifdef ALU_SEQ_OVF_EN
  assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with a behavioural ALU; expected results come from plain arithmetic.
// Checks ovf as well when ALU_SEQ_OVF_EN is defined.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int DATA_W = 16;
  localparam int OP_W   = 3;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic              z;
    logic              ovf;
    int                lat;
    int                acceptCycle;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  int   doneCount = 0;
  int   expectedDones = 0;
  exp_t sbQ[$];
  exp_t monExp;
  logic [DATA_W-1:0] aluRes;

  alu_seq_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  alu_seq #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural ALU: Z is simply "C is zero".
  always_comb begin
    aluRes = '0;
    case (bus.alu_op)
      3'd0: aluRes = bus.alu_a + bus.alu_b;
      3'd1: aluRes = bus.alu_a - bus.alu_b;
      3'd2: aluRes = bus.alu_b;
      3'd3: aluRes = '0;
      3'd4: aluRes = bus.alu_a - 16'd1;
      3'd5: aluRes = bus.alu_b << 1;
      3'd6: aluRes = bus.alu_b >> 1;
      default: aluRes = '0;
    endcase
  end

  assign bus.alu_c = aluRes;
  assign bus.alu_z = (aluRes == '0);

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference results straight from the arithmetic meaning of each command.
  function automatic exp_t refModel(input logic [1:0] c, input logic [2:0] op,
                                    input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    longint unsigned wide;
    logic [2:0] o;
    e.ovf = 1'b0;
    e.res = '0;
    e.lat = 2 * int'(a) + 3;
    e.acceptCycle = 0;
    case (c)
      2'd0: begin
        o = (op == 3'd7) ? 3'd3 : op;
        case (o)
          3'd0: e.res = a + b;
          3'd1: e.res = a - b;
          3'd2: e.res = b;
          3'd4: e.res = a - 16'd1;
          3'd5: e.res = b * 16'd2;
          3'd6: e.res = b / 16'd2;
          default: e.res = '0;
        endcase
        e.lat = 1;
      end
      2'd1: begin
        wide  = longint'(a) * longint'(b);
        e.res = wide[15:0];
        e.ovf = (wide > 64'd65535);
      end
      2'd2: begin
        wide  = longint'(b) << a;
        e.res = wide[15:0];
        e.ovf = ((wide >> 16) != 0);
      end
      default: e.res = b >> a;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Monitor: every done pulse pops one expectation and checks value and timing.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      doneCount++;
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone: got done=1, expected no pending command (cycle %0d)", cycle);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("result", bus.result, monExp.res);
        checkOutput("zero", bus.zero, monExp.z);
        checkOutput("latency", cycle - monExp.acceptCycle, monExp.lat);
`ifdef ALU_SEQ_OVF_EN
        checkOutput("ovf", bus.ovf, monExp.ovf);
`endif
      end
    end
  end

  task automatic waitIdle();
    int waitCnt = 0;
    while (bus.busy && waitCnt < 1000) begin
      @(negedge clk);
      waitCnt++;
    end
    if (bus.busy) checkOutput("idleTimeout", bus.busy, 1'b0);
  endtask

  task automatic applyStimulus(input logic [1:0] c, input logic [2:0] op,
                               input logic [15:0] a, input logic [15:0] b, input bit spurious);
    exp_t e;
    int busyCycles = 0;
    int addCount = 0;
    int waitCnt = 0;
    bit sawDone = 0;
    waitIdle();
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd   = c;
    bus.op_in = op;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk);
    #1;
    e = refModel(c, op, a, b);
    e.acceptCycle = cycle;
    sbQ.push_back(e);
    expectedDones++;
    @(negedge clk);
    bus.start = 1'b0;
    if (c == 2'd0) checkOutput("execAluOp", bus.alu_op, (op == 3'd7) ? 3'd3 : op);
    while (waitCnt < e.lat + 20) begin
      if (bus.busy) busyCycles++;
      if (bus.alu_op == ALU_ADD) addCount++;
      if (bus.done) begin
        sawDone = 1;
        if (spurious) bus.start = 1'b1;
      end else if (!bus.busy) begin
        break;
      end
      @(negedge clk);
      bus.start = 1'b0;
      waitCnt++;
    end
    checkOutput("sawDone", sawDone, 1'b1);
    checkOutput("busyCycles", busyCycles, (c == 2'd0) ? 2 : 2 * int'(a) + 4);
    if (c == 2'd1) checkOutput("addCount", addCount, a);
  endtask

  task automatic abortMidMul();
    int donesBefore;
    waitIdle();
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd   = 2'd1;
    bus.opa   = 16'd100;
    bus.opb   = 16'd3;
    @(negedge clk);
    bus.start = 1'b0;
    donesBefore = doneCount;
    repeat (20) @(negedge clk);
    bus.start = 1'b1;
    bus.cmd   = 2'd0;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busyMidMul", bus.busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abortBusy", bus.busy, 1'b0);
    checkOutput("abortDone", bus.done, 1'b0);
    checkOutput("abortResult", bus.result, 16'd0);
    checkOutput("abortZero", bus.zero, 1'b0);
    checkOutput("abortAluOp", bus.alu_op, ALU_ZER);
    checkOutput("abortAluA", bus.alu_a, 16'd0);
`ifdef ALU_SEQ_OVF_EN
    checkOutput("abortOvf", bus.ovf, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (250) @(negedge clk);
    checkOutput("abortNoDone", doneCount, donesBefore);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] c;
    logic [2:0] op;
    logic [15:0] a;
    logic [15:0] b;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.cmd   = 2'd0;
    bus.op_in = '0;
    bus.opa   = '0;
    bus.opb   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetBusy", bus.busy, 1'b0);
    checkOutput("resetDone", bus.done, 1'b0);
    checkOutput("resetResult", bus.result, 16'd0);
    checkOutput("resetZero", bus.zero, 1'b0);
    checkOutput("resetAluA", bus.alu_a, 16'd0);
    checkOutput("resetAluB", bus.alu_b, 16'd0);
    checkOutput("resetAluOp", bus.alu_op, ALU_ZER);
`ifdef ALU_SEQ_OVF_EN
    checkOutput("resetOvf", bus.ovf, 1'b0);
`endif
    rst = 1'b0;

    applyStimulus(2'd0, ALU_SUB, 16'd5, 16'd5, 1'b1);
    applyStimulus(2'd1, 3'd0, 16'd7, 16'd6, 1'b0);
    abortMidMul();
    applyStimulus(2'd1, 3'd0, 16'd0, 16'd123, 1'b1);
    applyStimulus(2'd3, 3'd0, 16'd15, 16'h8000, 1'b0);
    applyStimulus(2'd2, 3'd0, 16'd16, 16'd1, 1'b1);
    applyStimulus(2'd0, 3'd7, 16'd9, 16'd4, 1'b0);

    for (int i = 0; i < 30; i++) begin
      c = 2'($urandom_range(0, 3));
      b = 16'($urandom);
      if (c == 2'd0) begin
        op = 3'($urandom_range(0, 7));
        a  = 16'($urandom);
      end else begin
        op = 3'($urandom_range(0, 7));
        a  = 16'($urandom_range(0, 20));
      end
      applyStimulus(c, op, a, b, 1'($urandom_range(0, 1)));
    end

    waitIdle();
    repeat (5) @(negedge clk);
    checkOutput("queueEmpty", sbQ.size(), 0);
    checkOutput("doneCount", doneCount, expectedDones);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
